// File: rtl/ad_scan_scheduler_if.sv
// Requester and ADC-engine signal bundle for ad_scan_scheduler.
// The slave modport is the scheduler side. The master modport is the requester/engine side.
interface ad_scan_scheduler_if;
   logic [3:0] Req;
   logic [3:0] Gnt;
   logic [9:0] Result;
   logic       Result_Valid;
   logic       Conv_Start;
   logic [3:0] Conv_Addr;
   logic       Conv_Busy;
   logic       Conv_Done;
   logic [9:0] Conv_Data;
   logic       Err_Clr;
   logic       Timeout_Err;

   modport slave (
      input  Req, Conv_Busy, Conv_Done, Conv_Data, Err_Clr,
      output Gnt, Result, Result_Valid, Conv_Start, Conv_Addr,
             Timeout_Err
   );

   modport master (
      output Req, Conv_Busy, Conv_Done, Conv_Data, Err_Clr,
      input  Gnt, Result, Result_Valid, Conv_Start, Conv_Addr,
             Timeout_Err
   );
endinterface

// File: rtl/ad_scan_scheduler.sv
// Round-robin scan scheduler sharing one ADC serial engine among 4 requesters.
// Enforces an idle gap after each conversion and a bounded wait for Conv_Done.
module ad_scan_scheduler #(
   parameter logic [3:0] CH0_ADDR    = 4'b0000,
   parameter logic [3:0] CH1_ADDR    = 4'b0001,
   parameter logic [3:0] CH2_ADDR    = 4'b0010,
   parameter logic [3:0] CH3_ADDR    = 4'b0101,
   parameter int         GAP_CYC     = 1050,
   parameter int         TIMEOUT_CYC = 4095
) (
   input logic                CLK,
   input logic                RST,
   ad_scan_scheduler_if.slave bus
);
   localparam int CMAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [1:0]    idx, last, pick, cand;
   logic          arb, done_ok, tmo;

   function automatic logic [3:0] ch_addr(input logic [1:0] i);
      case (i)
         2'd0:    ch_addr = CH0_ADDR;
         2'd1:    ch_addr = CH1_ADDR;
         2'd2:    ch_addr = CH2_ADDR;
         default: ch_addr = CH3_ADDR;
      endcase
   endfunction

   // Scan offsets 4..1 so the lowest offset after last served wins.
   always_comb begin
      pick = last;
      cand = last;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (bus.Req[cand]) pick = cand;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      arb     = 1'b0;
      done_ok = 1'b0;
      tmo     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.Conv_Busy && (|bus.Req)) begin
               arb     = 1'b1;
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            state_d = WAIT_DONE;
            cnt_d   = '0;
         end
         WAIT_DONE: begin
            if (bus.Conv_Done) begin
               done_ok = 1'b1;
               state_d = GAP;
               cnt_d   = '0;
            end else if (cnt == TMO_LAST) begin
               tmo     = 1'b1;
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx              <= 2'd0;
         last             <= 2'd3;
         bus.Gnt          <= 4'b0000;
         bus.Result       <= 10'd0;
         bus.Result_Valid <= 1'b0;
         bus.Conv_Start   <= 1'b0;
         bus.Conv_Addr    <= 4'b0000;
         bus.Timeout_Err  <= 1'b0;
      end else begin
         bus.Conv_Start   <= arb;
         bus.Result_Valid <= done_ok;
         bus.Gnt          <= done_ok ? (4'b0001 << idx) : 4'b0000;
         if (arb) begin
            idx           <= pick;
            bus.Conv_Addr <= ch_addr(pick);
         end
         if (done_ok) bus.Result <= bus.Conv_Data;
         if (done_ok || tmo) last <= idx;
         // A timeout in the same cycle as Err_Clr must stay visible.
         if (tmo) bus.Timeout_Err <= 1'b1;
         else if (bus.Err_Clr) bus.Timeout_Err <= 1'b0;
      end
   end
endmodule
